// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the register-file FIFO controller.
// State encodings are fixed because the state is exported for debug.
package fifo_ctrl_pkg;

  localparam int FIFO_AW    = 3;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    NO_OP  = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    WR_RD  = 3'd4,
    WR_ERR = 3'd5,
    RD_ERR = 3'd6
  } state_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Requester/storage-side signal bundle of the FIFO controller.
// master = requester side, slave = the controller itself.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int AW = FIFO_AW
);
  logic          wr_en;
  logic          rd_en;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic          re;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   data_count;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
  state_t        state;

  modport master (
    output wr_en, rd_en,
    input  we, wr_addr, re, rd_addr, data_count, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err, state
  );

  modport slave (
    input  wr_en, rd_en,
    output we, wr_addr, re, rd_addr, data_count, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err, state
  );
endinterface

// File: rtl/fifo_ptr.sv
// Wrapping AW-bit pointer register; used for both head and tail.
module fifo_ptr #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + AW'(1);
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Push/pop arbitration for an 8-entry register-file FIFO: pointers, occupancy,
// status flags, per-request ack/err pulses and a debug state register.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int AW    = FIFO_AW,
  parameter int DEPTH = FIFO_DEPTH
) (
  input logic      clk,
  input logic      reset,
  fifo_ctrl_if.slave bus
);

  logic          push_acc;
  logic          pop_acc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count_next;
  state_t        state_next;

  // full/empty are registered from count_next, so they always reflect the live count
  assign push_acc   = bus.wr_en & ~bus.full & ~reset;
  assign pop_acc    = bus.rd_en & ~bus.empty;
  assign bus.we     = push_acc;
  assign bus.wr_addr = tail;
  assign count_next = bus.data_count + (AW+1)'(push_acc) - (AW+1)'(pop_acc);

  fifo_ptr #(.AW(AW)) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (push_acc),
    .ptr   (tail)
  );

  fifo_ptr #(.AW(AW)) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_acc),
    .ptr   (head)
  );

  always_comb begin
    state_next = NO_OP;
    unique case ({bus.wr_en, bus.rd_en})
      2'b10:   state_next = bus.full  ? WR_ERR : WRITE;
      2'b01:   state_next = bus.empty ? RD_ERR : READ;
      2'b11: begin
        if (bus.empty)
          state_next = WRITE;
        else if (bus.full)
          state_next = READ;
        else
          state_next = WR_RD;
      end
      default: state_next = NO_OP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.state      <= INIT;
      bus.data_count <= '0;
      bus.full       <= 1'b0;
      bus.empty      <= 1'b1;
      bus.re         <= 1'b0;
      bus.rd_addr    <= '0;
      bus.wr_ack     <= 1'b0;
      bus.wr_err     <= 1'b0;
      bus.rd_ack     <= 1'b0;
      bus.rd_err     <= 1'b0;
    end else begin
      bus.state      <= state_next;
      bus.data_count <= count_next;
      bus.full       <= (count_next == (AW+1)'(DEPTH));
      bus.empty      <= (count_next == '0);
      bus.re         <= pop_acc;
      if (pop_acc)
        bus.rd_addr  <= head;
      bus.wr_ack     <= push_acc;
      bus.wr_err     <= bus.wr_en & ~push_acc;
      bus.rd_ack     <= pop_acc;
      bus.rd_err     <= bus.rd_en & ~pop_acc;
    end
  end

endmodule
